mmv_input_packer: RTL
=====================

// Module: mmv_input_packer
// PURPOSE
// - Upstream neighbour of mmv_input_swu: gathers MMV_IN consecutive SIMD-wide words from a narrow AXI-Stream into one MMV_IN*SIMD*IP_PRECISION beat.
// - Keeps row alignment: a beat never spans two image rows.
// - If words per row is not a multiple of MMV_IN, the last beat of each row is zero-padded. The SWU then always sees row-aligned multi-pixel beats.
// PARAMETERS
// - MMV_IN        3  words packed per output beat (>=1)
// - SIMD          1  channels per input word
// - IP_PRECISION  8  bits per channel
// - IFMChannels   2  channels per pixel; must be divisible by SIMD
// - IFMWidth      6  pixels per row
// - IFMHeight     6  rows per frame
// - Derived: WPR = IFMWidth*IFMChannels/SIMD (words per row); W = SIMD*IP_PRECISION
// PORTS
// - clk            in   1          clock; all logic on rising edge
// - resetn         in   1          asynchronous, active-low reset
// - ip_axis_tdata  in   W          input word
// - ip_axis_tvalid in   1          input valid
// - ip_axis_tready out  1          input ready
// - op_axis_tdata  out  MMV_IN*W   packed beat; lane 0 (first word) at LSBs
// - op_axis_tvalid out  1          output valid
// - op_axis_tready in   1          output ready
// - op_axis_tlast  out  1          only with MMV_PACK_TLAST_EN
// BEHAVIOUR
// - One clock. Reset is asynchronous, active-low (resetn), and clears all state at once.
// - Reset values:
//   - op_axis_tvalid=0, op_axis_tdata=0, op_axis_tlast=0
//   - lane, word and row counters = 0; staging register = 0
// - ip_axis_tready = ~op_axis_tvalid | op_axis_tready (combinational). It is low only while a held output beat is stalled.
// - Input accept (valid&ready):
//   - Word is written into staging lane `lane`.
//   - lane increments; word counter (0..WPR-1) increments.
// - Beat completes on the accepting edge when lane==MMV_IN-1 or word==WPR-1. On that edge:
//   - Staging lanes 0..lane, including the current word, load op_axis_tdata.
//   - Lanes above `lane` load zero.
//   - op_axis_tvalid is set.
//   - lane clears and staging clears.
//   - If word==WPR-1: word clears and row increments; row wraps to 0 after IFMHeight-1.
// - Latency: the completing word appears on op_axis_tdata the cycle after it is accepted.
// - Throughput: 1 word/cycle sustained; one beat every MMV_IN words. Partial row-end beats are the exception.
// - Output handshake:
//   - op_axis_tdata and op_axis_tvalid are held stable while tvalid&~tready.
//   - tvalid clears on transfer unless a new beat completes on the same edge.
//   - Simultaneous output transfer and beat completion: the new beat loads with no bubble.
// - No state machine beyond counters: FILL (lane<MMV_IN-1) / COMPLETE (beat emitted) is implicit in lane/word.
// - Reset asserted mid-row discards the partial beat and any held output. The next word after release is lane 0 of row 0.
// - A stalled input (tvalid low) leaves all counters unchanged. There are no timeouts or auto-flush.
// CONFIGURATION
// - Macro MMV_PACK_TLAST_EN.
// - Defined:
//   - Port op_axis_tlast exists.
//   - It is 1 with the beat that completes word WPR-1 of row IFMHeight-1 (last beat of frame), else 0.
//   - It is registered and held with tdata while stalled.
// - Undefined: the port is absent; the row counter may be optimised away. Data behaviour is identical.
// TESTING
// - Defaults, tready=1, input words 01..0C -> 4 beats 030201,060504,090807,0C0B0A; one beat per 3 accepted words, latency 1 cycle.
// - IFMWidth=5 (WPR=10), words 01..0A -> beats 030201,060504,090807,00000A.
//   - Next word 0B starts a new beat in lane 0.
// - op_axis_tready=0 for 5 cycles with a beat held -> tdata/tvalid stable, ip_axis_tready=0.
//   - After release, no word is lost or duplicated.
// - resetn pulsed low mid-beat after 2 words -> outputs 0 immediately (async); next words 11,12,13 -> beat 131211.
// - With MMV_PACK_TLAST_EN, a full 6x6 frame (72 words, 24 beats) -> op_axis_tlast=1 only on beat 24.
//   - Second frame repeats the pattern.
// - MMV_IN=1 -> every accepted word is emitted next cycle unchanged; back-to-back with tready=1.

Source files
------------

// File: rtl/mmv_input_packer.sv
// ============================================================================
// Module      : mmv_input_packer
// Description : Packs MMV_IN consecutive SIMD-wide input words into one wide
//               AXI-Stream beat without ever letting a beat span two image
//               rows; the last beat of a row is zero-padded when the row
//               length is not a multiple of MMV_IN.
//               Optional feature macro: MMV_PACK_TLAST_EN adds op_axis_tlast,
//               marking the final beat of each frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mmv_input_packer #(
  parameter int MMV_IN       = 3,
  parameter int SIMD         = 1,
  parameter int IP_PRECISION = 8,
  parameter int IFMChannels  = 2,
  parameter int IFMWidth     = 6,
  parameter int IFMHeight    = 6
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic [SIMD*IP_PRECISION-1:0]          ip_axis_tdata,
  input  logic                                  ip_axis_tvalid,
  output logic                                  ip_axis_tready,
  output logic [MMV_IN*SIMD*IP_PRECISION-1:0]   op_axis_tdata,
  output logic                                  op_axis_tvalid,
  input  logic                                  op_axis_tready
`ifdef MMV_PACK_TLAST_EN
  ,
  output logic                                  op_axis_tlast
`endif
);

  localparam int c_w      = SIMD * IP_PRECISION;
  localparam int c_ow     = MMV_IN * c_w;
  localparam int c_wpr    = IFMWidth * IFMChannels / SIMD;
  localparam int c_lane_w = (MMV_IN > 1) ? $clog2(MMV_IN) : 1;
  localparam int c_word_w = (c_wpr > 1) ? $clog2(c_wpr) : 1;

  localparam logic [c_lane_w-1:0] c_last_lane = c_lane_w'(MMV_IN - 1);
  localparam logic [c_word_w-1:0] c_last_word = c_word_w'(c_wpr - 1);

  // Reject configurations where a pixel does not split into whole words.
  if (((IFMChannels % SIMD) != 0) || (IFMHeight < 1) || (MMV_IN < 1)) begin : g_bad_cfg
    $error("mmv_input_packer: illegal parameter combination");
  end

  logic [c_lane_w-1:0] r_lane;
  logic [c_word_w-1:0] r_word;
  logic [c_ow-1:0]     r_stage;
  logic [c_ow-1:0]     r_tdata;
  logic                r_tvalid;

  logic                w_accept;
  logic                w_row_end;
  logic                w_beat_done;
  logic [c_ow-1:0]     w_beat;

  assign ip_axis_tready = ~r_tvalid | op_axis_tready;
  assign w_accept       = ip_axis_tvalid & ip_axis_tready;
  assign w_row_end      = (r_word == c_last_word);
  assign w_beat_done    = (r_lane == c_last_lane) | w_row_end;

  // Beat as it would look with the current word placed: filled lanes from
  // staging, current word in lane r_lane, lanes above it forced to zero.
  for (genvar l = 0; l < MMV_IN; l++) begin : g_lane
    assign w_beat[l*c_w +: c_w] =
        (c_lane_w'(l) <  r_lane) ? r_stage[l*c_w +: c_w] :
        (c_lane_w'(l) == r_lane) ? ip_axis_tdata :
                                   {c_w{1'b0}};
  end

  // Lane/word position tracking and staging of a partially filled beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lane  <= '0;
      r_word  <= '0;
      r_stage <= '0;
    end else if (w_accept) begin
      if (w_beat_done) begin
        r_lane  <= '0;
        r_stage <= '0;
      end else begin
        r_lane  <= r_lane + c_lane_w'(1);
        r_stage <= w_beat;
      end
      r_word <= w_row_end ? '0 : r_word + c_word_w'(1);
    end
  end

  // Output beat register: loads on completion, held while stalled, dropped
  // after transfer unless a new beat completes on the same edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
    end else if (w_accept && w_beat_done) begin
      r_tdata  <= w_beat;
      r_tvalid <= 1'b1;
    end else if (op_axis_tready) begin
      r_tvalid <= 1'b0;
    end
  end

  assign op_axis_tdata  = r_tdata;
  assign op_axis_tvalid = r_tvalid;

`ifdef MMV_PACK_TLAST_EN
  localparam int c_row_w = (IFMHeight > 1) ? $clog2(IFMHeight) : 1;
  localparam logic [c_row_w-1:0] c_last_row = c_row_w'(IFMHeight - 1);

  logic [c_row_w-1:0] r_row;
  logic               r_tlast;

  // Row counter, advanced on the word that closes each row.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_row <= '0;
    end else if (w_accept && w_row_end) begin
      r_row <= (r_row == c_last_row) ? '0 : r_row + c_row_w'(1);
    end
  end

  // Frame-end flag travels with the beat and is held with it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tlast <= 1'b0;
    end else if (w_accept && w_beat_done) begin
      r_tlast <= w_row_end && (r_row == c_last_row);
    end
  end

  assign op_axis_tlast = r_tlast;
`endif

endmodule

`default_nettype wire
